// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS multicycle PC-sequencing control.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W = 4;

  // State encodings
  localparam logic [STATE_W-1:0] S_FETCH      = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE     = 4'd1;
  localparam logic [STATE_W-1:0] S_EXEC       = 4'd2;
  localparam logic [STATE_W-1:0] S_JR         = 4'd3;
  localparam logic [STATE_W-1:0] S_BRANCH     = 4'd4;
  localparam logic [STATE_W-1:0] S_JUMP       = 4'd5;
  localparam logic [STATE_W-1:0] S_ERET       = 4'd6;
  localparam logic [STATE_W-1:0] S_EXC_SAVE   = 4'd7;
  localparam logic [STATE_W-1:0] S_EXC_VECTOR = 4'd8;

  // Opcode / funct constants
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_ERET  = 6'h10;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  // PC-source mux selects
  localparam logic [1:0] PC_SRC_ALU_RESULT = 2'b00;
  localparam logic [1:0] PC_SRC_ALU_OUT    = 2'b01;
  localparam logic [1:0] PC_SRC_TARGET     = 2'b10;
  localparam logic [1:0] PC_SRC_EPC        = 2'b11;

  // Exception cause codes
  localparam int unsigned CAUSE_UNDEF = 0;
  localparam int unsigned CAUSE_OVF   = 1;

endpackage

// File: rtl/pc_seq_decode.sv
// Opcode/funct classifier giving the state that follows DECODE.
// PC_SEQ_CTRL_BNE_EN: when defined, bne is decoded as an inverted branch.
module pc_seq_decode
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OP_W = 6
) (
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    funct,
  output logic [STATE_W-1:0] next_state_c,
  output logic               is_link_c,
  output logic               is_bne_c
);

  // Classify the instruction; anything unrecognised traps as undefined
  always_comb begin
    next_state_c = S_EXC_SAVE;
    is_link_c    = 1'b0;
    is_bne_c     = 1'b0;
    if (opcode == OP_W'(OP_RTYPE)) begin
      next_state_c = (funct == OP_W'(FN_JR)) ? S_JR : S_EXEC;
    end else if (opcode == OP_W'(OP_BEQ)) begin
      next_state_c = S_BRANCH;
`ifdef PC_SEQ_CTRL_BNE_EN
    end else if (opcode == OP_W'(OP_BNE)) begin
      next_state_c = S_BRANCH;
      is_bne_c     = 1'b1;
`endif
    end else if (opcode == OP_W'(OP_J) || opcode == OP_W'(OP_JAL)) begin
      next_state_c = S_JUMP;
      is_link_c    = (opcode == OP_W'(OP_JAL));
    end else if (opcode == OP_W'(OP_ERET)) begin
      next_state_c = S_ERET;
    end else if (opcode == OP_W'(OP_LW)   || opcode == OP_W'(OP_SW)   ||
                 opcode == OP_W'(OP_ADDI) || opcode == OP_W'(OP_ANDI) ||
                 opcode == OP_W'(OP_ORI)  || opcode == OP_W'(OP_LUI)) begin
      next_state_c = S_EXEC;
    end
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Multicycle next-PC sequencing FSM for the MIPS core.
// PC_SEQ_CTRL_BNE_EN: when defined, opcode 0x05 branches on ~alu_zero;
// otherwise it traps as an undefined instruction.
module pc_seq_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned CAUSE_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    funct,
  input  logic               alu_zero,
  input  logic               alu_overflow,
  input  logic               datapath_done,
  output logic [1:0]         pc_src,
  output logic               pc_write,
  output logic               ir_write,
  output logic               vec_sel,
  output logic               link_write,
  output logic               epc_write,
  output logic               cause_write,
  output logic [CAUSE_W-1:0] cause,
  output logic               datapath_go,
  output logic [3:0]         state_o
);

  logic [STATE_W-1:0] state;
  logic               is_link;
  logic               is_bne;
  logic [CAUSE_W-1:0] cause_q;

  logic [STATE_W-1:0] dec_next;
  logic               dec_link;
  logic               dec_bne;

  pc_seq_decode #(.OP_W(OP_W)) u_decode (
    .opcode       (opcode),
    .funct        (funct),
    .next_state_c (dec_next),
    .is_link_c    (dec_link),
    .is_bne_c     (dec_bne)
  );

  // State register plus instruction flags captured in DECODE / EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      is_link <= 1'b0;
      is_bne  <= 1'b0;
      cause_q <= '0;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          state   <= dec_next;
          is_link <= dec_link;
          is_bne  <= dec_bne;
          if (dec_next == S_EXC_SAVE) cause_q <= CAUSE_W'(CAUSE_UNDEF);
        end
        S_EXEC: begin
          if (datapath_done) begin
            if (alu_overflow) begin
              state   <= S_EXC_SAVE;
              cause_q <= CAUSE_W'(CAUSE_OVF);
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_EXC_SAVE: state <= S_EXC_VECTOR;
        S_JR, S_BRANCH, S_JUMP, S_ERET, S_EXC_VECTOR: state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Output decode from state; everything held low while reset is asserted
  always_comb begin
    pc_src      = PC_SRC_ALU_RESULT;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    vec_sel     = 1'b0;
    link_write  = 1'b0;
    epc_write   = 1'b0;
    cause_write = 1'b0;
    cause       = '0;
    datapath_go = 1'b0;
    state_o     = 4'(state);
    if (reset) begin
      state_o = '0;
    end else begin
      case (state)
        S_FETCH: begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_SRC_ALU_RESULT;
        end
        S_EXEC: datapath_go = 1'b1;
        S_JR: begin
          pc_src   = PC_SRC_ALU_RESULT;
          pc_write = 1'b1;
        end
        S_BRANCH: begin
          pc_src   = PC_SRC_ALU_OUT;
          pc_write = is_bne ? ~alu_zero : alu_zero;
        end
        S_JUMP: begin
          pc_src     = PC_SRC_TARGET;
          pc_write   = 1'b1;
          link_write = is_link;
        end
        S_ERET: begin
          pc_src   = PC_SRC_EPC;
          pc_write = 1'b1;
        end
        S_EXC_SAVE: begin
          epc_write   = 1'b1;
          cause_write = 1'b1;
          cause       = cause_q;
        end
        S_EXC_VECTOR: begin
          pc_src   = PC_SRC_TARGET;
          vec_sel  = 1'b1;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed self-checking bench for pc_seq_ctrl.
module tb_pc_seq_ctrl;
  import mips_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       alu_overflow;
  logic       datapath_done;
  logic [1:0] pc_src;
  logic       pc_write;
  logic       ir_write;
  logic       vec_sel;
  logic       link_write;
  logic       epc_write;
  logic       cause_write;
  logic [1:0] cause;
  logic       datapath_go;
  logic [3:0] state_o;

  int checks = 0;
  int failures = 0;

  pc_seq_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct         (funct),
    .alu_zero      (alu_zero),
    .alu_overflow  (alu_overflow),
    .datapath_done (datapath_done),
    .pc_src        (pc_src),
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .vec_sel       (vec_sel),
    .link_write    (link_write),
    .epc_write     (epc_write),
    .cause_write   (cause_write),
    .cause         (cause),
    .datapath_go   (datapath_go),
    .state_o       (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: {state, pc_src, pc_write, ir_write, vec_sel, link, epc, cause_wr, cause, go}
  logic [14:0] obs;
  assign obs = {state_o, pc_src, pc_write, ir_write, vec_sel, link_write,
                epc_write, cause_write, cause, datapath_go};

  function automatic logic [14:0] ov(input logic [3:0] st, input logic [1:0] src,
                                     input logic pcw, input logic irw, input logic vs,
                                     input logic lnk, input logic epc, input logic cw,
                                     input logic [1:0] cs, input logic go);
    return {st, src, pcw, irw, vs, lnk, epc, cw, cs, go};
  endfunction

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%04h exp=%04h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [14:0] fetch_v, decode_v, exec_v;

  initial begin
    fetch_v  = ov(S_FETCH,  2'b00, 1, 1, 0, 0, 0, 0, 2'd0, 0);
    decode_v = ov(S_DECODE, 2'b00, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    exec_v   = ov(S_EXEC,   2'b00, 0, 0, 0, 0, 0, 0, 2'd0, 1);

    reset = 1'b1; opcode = '0; funct = '0;
    alu_zero = 1'b0; alu_overflow = 1'b0; datapath_done = 1'b0;
    #2;
    check("reset_all_zero", obs, 15'd0);
    #10;
    reset = 1'b0;
    #1;
    check("fetch_after_reset", obs, fetch_v);

    // beq taken
    opcode = 6'h04; alu_zero = 1'b1;
    tick(); check("beq_decode", obs, decode_v);
    tick(); check("beq_taken", obs, ov(S_BRANCH, 2'b01, 1, 0, 0, 0, 0, 0, 2'd0, 0));
    tick(); check("beq_fetch", obs, fetch_v);

    // beq not taken
    alu_zero = 1'b0;
    tick(); check("beqn_decode", obs, decode_v);
    tick(); check("beq_not_taken", obs, ov(S_BRANCH, 2'b01, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    tick(); check("beqn_fetch", obs, fetch_v);

    // jal
    opcode = 6'h03;
    tick(); check("jal_decode", obs, decode_v);
    tick(); check("jal_jump", obs, ov(S_JUMP, 2'b10, 1, 0, 0, 1, 0, 0, 2'd0, 0));
    tick(); check("jal_fetch", obs, fetch_v);

    // j
    opcode = 6'h02;
    tick(); check("j_decode", obs, decode_v);
    tick(); check("j_jump", obs, ov(S_JUMP, 2'b10, 1, 0, 0, 0, 0, 0, 2'd0, 0));
    tick(); check("j_fetch", obs, fetch_v);

    // lw, done on the third EXEC cycle
    opcode = 6'h23;
    tick(); check("lw_decode", obs, decode_v);
    tick(); check("lw_exec1", obs, exec_v);
    tick(); check("lw_exec2", obs, exec_v);
    tick(); check("lw_exec3", obs, exec_v);
    datapath_done = 1'b1;
    tick(); check("lw_fetch", obs, fetch_v);
    datapath_done = 1'b0;

    // add with overflow; overflow ignored until done
    opcode = 6'h00; funct = 6'h20; alu_overflow = 1'b1;
    tick(); check("add_decode", obs, decode_v);
    tick(); check("add_exec1", obs, exec_v);
    tick(); check("add_exec2", obs, exec_v);
    datapath_done = 1'b1;
    tick(); check("ovf_save", obs, ov(S_EXC_SAVE, 2'b00, 0, 0, 0, 0, 1, 1, 2'd1, 0));
    datapath_done = 1'b0; alu_overflow = 1'b0;
    tick(); check("ovf_vector", obs, ov(S_EXC_VECTOR, 2'b10, 1, 0, 1, 0, 0, 0, 2'd0, 0));
    tick(); check("ovf_fetch", obs, fetch_v);

    // undefined opcode 0x3F (cause register must reload to 0)
    opcode = 6'h3F; funct = 6'h00;
    tick(); check("undef_decode", obs, decode_v);
    tick(); check("undef_save", obs, ov(S_EXC_SAVE, 2'b00, 0, 0, 0, 0, 1, 1, 2'd0, 0));
    tick(); check("undef_vector", obs, ov(S_EXC_VECTOR, 2'b10, 1, 0, 1, 0, 0, 0, 2'd0, 0));
    tick(); check("undef_fetch", obs, fetch_v);

    // opcode 0x05 with alu_zero=0
    opcode = 6'h05; alu_zero = 1'b0;
    tick(); check("bne_decode", obs, decode_v);
`ifdef PC_SEQ_CTRL_BNE_EN
    tick(); check("bne_taken", obs, ov(S_BRANCH, 2'b01, 1, 0, 0, 0, 0, 0, 2'd0, 0));
`else
    tick(); check("bne_undef_save", obs, ov(S_EXC_SAVE, 2'b00, 0, 0, 0, 0, 1, 1, 2'd0, 0));
    tick(); check("bne_undef_vector", obs, ov(S_EXC_VECTOR, 2'b10, 1, 0, 1, 0, 0, 0, 2'd0, 0));
`endif
    tick(); check("bne_fetch", obs, fetch_v);

    // eret with stray done/overflow that must be ignored
    opcode = 6'h10; datapath_done = 1'b1; alu_overflow = 1'b1;
    tick(); check("eret_decode", obs, decode_v);
    tick(); check("eret", obs, ov(S_ERET, 2'b11, 1, 0, 0, 0, 0, 0, 2'd0, 0));
    tick(); check("eret_fetch", obs, fetch_v);
    datapath_done = 1'b0; alu_overflow = 1'b0;

    // jr
    opcode = 6'h00; funct = 6'h08;
    tick(); check("jr_decode", obs, decode_v);
    tick(); check("jr", obs, ov(S_JR, 2'b00, 1, 0, 0, 0, 0, 0, 2'd0, 0));
    tick(); check("jr_fetch", obs, fetch_v);

    // reset pulse in EXEC
    opcode = 6'h2B; funct = 6'h00;
    tick(); check("sw_decode", obs, decode_v);
    tick(); check("sw_exec", obs, exec_v);
    reset = 1'b1;
    #1;
    check("reset_in_exec", obs, 15'd0);
    tick(); check("reset_held", obs, 15'd0);
    reset = 1'b0;
    #1;
    check("release_fetch", obs, fetch_v);
    tick(); check("release_decode", obs, decode_v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Multicycle control FSM that sequences next-PC selection for the MIPS core.
- Drives the 4-way PC-source mux select (00 ALUResult, 01 ALUOut, 10 jump/vector target, 11 EPC).
- Also drives the PC/IR write enables and the EPC/Cause capture enables.
- Sits between the instruction register decode and the PC-update datapath.
- Hands non-control instructions to the datapath sequencer via a go/done handshake.

Parameters:
- OP_W, 6, opcode and funct field width
- CAUSE_W, 2, width of exception cause code

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; forces FETCH immediately
- opcode  input  6  IR[31:26]; sampled in DECODE
- funct  input  6  IR[5:0]; sampled in DECODE
- alu_zero  input  1  ALU zero flag; used in BRANCH
- alu_overflow  input  1  ALU overflow; sampled in the cycle datapath_done=1
- datapath_done  input  1  datapath sequencer finished the current instruction
- pc_src  output  2  PC-source mux select
- pc_write  output  1  PC load enable
- ir_write  output  1  IR load enable
- vec_sel  output  1  target mux selects the exception vector instead of the jump target
- link_write  output  1  write PC into $31 (jal)
- epc_write  output  1  EPC capture enable
- cause_write  output  1  Cause capture enable
- cause  output  CAUSE_W  0 = undefined opcode, 1 = arithmetic overflow
- datapath_go  output  1  level request to the datapath sequencer
- state_o  output  4  current state encoding, for debug

Behaviour:
- Reset: state = FETCH. All outputs 0 except as decoded from FETCH after reset deasserts. During reset every output is 0, including cause.
- Outputs decode combinationally from state. Only BRANCH pc_write also depends on alu_zero.
- FETCH (1 cycle): ir_write=1, pc_write=1, pc_src=00 (PC <- PC+4). Next state DECODE.
- DECODE (1 cycle): all enables 0. Next state by opcode:
  - 0x00 with funct 0x08 (jr) -> JR
  - other 0x00 -> EXEC
  - 0x04 -> BRANCH
  - 0x02 / 0x03 -> JUMP; 0x03 is registered as is_link
  - 0x10 -> ERET
  - 0x23, 0x2B, 0x08, 0x0C, 0x0D, 0x0F -> EXEC
  - anything else -> EXC_SAVE with cause=0 registered
- EXEC: datapath_go=1, held until datapath_done=1.
  - On the done cycle, if alu_overflow=1 -> EXC_SAVE with cause=1; else -> FETCH.
  - No timeout; the FSM waits indefinitely.
- JR (1 cycle): pc_src=00, pc_write=1 (ALU passes rs). -> FETCH.
- BRANCH (1 cycle): pc_src=01, pc_write=alu_zero. -> FETCH.
- JUMP (1 cycle): pc_src=10, vec_sel=0, pc_write=1, link_write=is_link. -> FETCH.
- ERET (1 cycle): pc_src=11, pc_write=1. -> FETCH.
- EXC_SAVE (1 cycle): epc_write=1, cause_write=1, cause=registered code. -> EXC_VECTOR.
- EXC_VECTOR (1 cycle): pc_src=10, vec_sel=1, pc_write=1. -> FETCH.
- Instruction latency in cycles:
  - 3: JR, BRANCH, JUMP, ERET
  - 2 + N: EXEC, where N = cycles to datapath_done
  - 4: undefined opcode (FETCH, DECODE, EXC_SAVE, EXC_VECTOR)
- datapath_done outside EXEC is ignored.
- alu_overflow is ignored outside the EXEC done cycle.
- Reset asserted mid-instruction (any state, including EXEC with go high):
  - state returns to FETCH asynchronously;
  - datapath_go drops immediately;
  - is_link and the cause register clear to 0.
- Illegal state encodings recover to FETCH on the next edge.

Optional Feature:
- Macro: PC_SEQ_CTRL_BNE_EN.
- Defined: opcode 0x05 -> BRANCH with the condition inverted (pc_write = ~alu_zero), using a registered is_bne flag.
- Undefined: opcode 0x05 is treated as undefined -> EXC_SAVE with cause=0.

Decomposition:
- Shared package (mips_ctrl_pkg) holds:
  - state encoding localparams;
  - opcode and funct constants (OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ERET, OP_LW, OP_SW, FN_JR);
  - PC_SRC_* select codes (00/01/10/11);
  - CAUSE_* codes.
- One natural sub-module: pc_seq_decode, the combinational opcode/funct -> next-state classifier used in DECODE. The FSM registers and output decode stay in pc_seq_ctrl.

Test Plan:
- beq, alu_zero=1 in BRANCH -> pc_src=01 with pc_write=1 exactly one cycle; FETCH 3 cycles after the previous FETCH. Repeat with alu_zero=0 -> pc_write stays 0.
- jal (opcode 0x03) -> JUMP cycle shows pc_src=10, vec_sel=0, pc_write=1, link_write=1. Plain j (0x02) -> link_write=0.
- lw (0x23), datapath_done raised after 3 cycles with alu_overflow=0 -> datapath_go high 3 cycles, then FETCH. Repeat add (0x00/0x20) with alu_overflow=1 -> epc_write=1, cause_write=1, cause=1, then EXC_VECTOR pc_src=10, vec_sel=1.
- Opcode 0x3F -> 4-cycle sequence, cause=0, EPC captured. Opcode 0x05 -> BRANCH with inverted condition when PC_SEQ_CTRL_BNE_EN is defined, exception cause=0 when it is not.
- Opcode 0x10 (eret) -> pc_src=11, pc_write=1 for one cycle, then FETCH.
- Reset pulse in EXEC with datapath_go=1 -> datapath_go=0 in the same cycle, all outputs 0; after release, FETCH with ir_write=1 on the first edge.
